id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have rst_i  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk_i.
REQ-003 SHALL have id_valid_i  input  1  ID stage holds a real instruction this cycle.
REQ-004 SHALL have flush_i  input  1  branch resolved taken; squash the ID instruction.
REQ-005 SHALL have AluOp_i  input  6 and AluSrc_i, RegDst_i, MemRead_i, MemWrite_i, Branch_i, RegWrite_i, MemToReg_i  input  1 each: decoder control for the ID instruction.
REQ-006 SHALL have pc_plus4_i, rs_data_i, rt_data_i, imm_sext_i  input  32 each: ID datapath values.
REQ-007 SHALL have rs_addr_i, rt_addr_i, rd_addr_i  input  5 each: register specifiers; funct_i  input  6.
REQ-008 SHALL have AluOp_o (6), AluSrc_o, MemRead_o, MemWrite_o, Branch_o, RegWrite_o, MemToReg_o (1 each)  output: registered control to EX.
REQ-009 SHALL have pc_plus4_o, rs_data_o, rt_data_o, imm_sext_o (32), rs_addr_o, rt_addr_o, wr_addr_o (5), funct_o (6)  output: registered datapath to EX.
REQ-010 SHALL have valid_o  output  1  EX holds a real instruction.
REQ-011 SHALL have stall_o  output  1  combinational load-use stall request to PC and IF/ID (hold).
REQ-012 SHALL have stall_cnt_o  output  16  saturating count of load-use bubble cycles.

Function
REQ-013 wr_addr_o SHALL capture RegDst_i ? rd_addr_i : rt_addr_i; RegDst is not forwarded past this stage.
REQ-014 uses_rt (internal) SHALL be RegDst_i | MemWrite_i | Branch_i; ADDI/SLTIU/ORI/LW do not read rt.
REQ-015 stall_o SHALL be 1 iff id_valid_i & valid_o & MemRead_o & (rt_addr_o != 0) & ((rt_addr_o == rs_addr_i) | (uses_rt & rt_addr_o == rt_addr_i)) & ~flush_i.
REQ-016 Each edge SHALL perform exactly one action, priority high to low: flush_i -> bubble; stall_o -> bubble; else load.
REQ-017 Load: all outputs take their input counterparts; valid_o <= id_valid_i.
REQ-018 Bubble: all control outputs, all datapath outputs and valid_o SHALL become 0 (identical to the decoder's default/NOP encoding).
REQ-019 If id_valid_i=0 on a load, control outputs SHALL be forced to 0 regardless of decoder inputs.
REQ-020 Latency SHALL be one cycle ID->EX; a load-use pair SHALL incur exactly one bubble, after which the consumer loads (producer now past EX, so stall_o drops).
REQ-021 stall_cnt_o SHALL increment by 1 on every edge where a bubble is caused by stall_o (not flush_i), saturating at 16'hFFFF with no wrap.
REQ-022 flush_i and a stall condition in the same cycle: flush_i wins, stall_o=0, counter unchanged.
REQ-023 rt_addr_o = 0 (load to $zero) SHALL never stall.
REQ-024 Back-to-back LW with dependent LW SHALL stall once per dependent pair; no state machine beyond the pipeline register and counter is required.

Reset
REQ-025 While rst_i=0 all outputs SHALL be 0, including valid_o and stall_cnt_o; stall_o SHALL be 0 (valid_o=0).
REQ-026 Reset asserted mid-stall SHALL clear the register and counter at once; first edge after release SHALL perform a normal load.

Verification
REQ-027 Reset: rst_i=0 with random inputs and clocks -> all outputs 0; release, ADDI (op 001000) valid -> next edge AluOp_o=000001, AluSrc_o=1, RegWrite_o=1, wr_addr_o=rt_addr_i.
REQ-028 Load-use: EX holds LW rt=8; ID R-type rs=8 -> stall_o=1, next edge valid_o=0 and controls 0, stall_cnt_o=1; following edge R-type loads, stall_o=0.
REQ-029 No false stall: EX LW rt=8; ID ORI rs=3 rt=8 -> stall_o=0 (ORI does not read rt); ID SW rs=3 rt=8 -> stall_o=1.
REQ-030 Zero register: EX LW rt=0; ID R-type rs=0 -> stall_o=0, stall_cnt_o unchanged.
REQ-031 Flush priority: stall condition plus flush_i=1 -> stall_o=0, bubble inserted, stall_cnt_o unchanged.
REQ-032 Saturation: preload via 65535 stall bubbles -> stall_cnt_o=16'hFFFF; one more stall -> remains 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Control is cleared on a bubble or an invalid ID slot; flush takes priority over stall.
module id_ex_stage #(
  parameter int unsigned CntWidth = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic        flush_i,
  input  logic [5:0]  AluOp_i,
  input  logic        AluSrc_i,
  input  logic        RegDst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        Branch_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [31:0] imm_sext_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [5:0]  funct_i,
  output logic [5:0]  AluOp_o,
  output logic        AluSrc_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        Branch_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o,
  output logic [31:0] imm_sext_o,
  output logic [4:0]  rs_addr_o,
  output logic [4:0]  rt_addr_o,
  output logic [4:0]  wr_addr_o,
  output logic [5:0]  funct_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic [15:0] stall_cnt_o
);

  logic                uses_rt;
  logic                rt_hit;
  logic [CntWidth-1:0] cnt_q;

  // Immediate-form instructions (ADDI, ORI, SLTIU, LW) never read rt.
  assign uses_rt = RegDst_i | MemWrite_i | Branch_i;
  assign rt_hit  = (rt_addr_o == rs_addr_i) | (uses_rt & (rt_addr_o == rt_addr_i));

  always_comb begin
    stall_o = id_valid_i & valid_o & MemRead_o & (rt_addr_o != 5'd0) & rt_hit & ~flush_i;
  end

  assign stall_cnt_o = 16'(cnt_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      AluOp_o    <= '0;
      AluSrc_o   <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      Branch_o   <= 1'b0;
      RegWrite_o <= 1'b0;
      MemToReg_o <= 1'b0;
      pc_plus4_o <= '0;
      rs_data_o  <= '0;
      rt_data_o  <= '0;
      imm_sext_o <= '0;
      rs_addr_o  <= '0;
      rt_addr_o  <= '0;
      wr_addr_o  <= '0;
      funct_o    <= '0;
      valid_o    <= 1'b0;
    end else if (flush_i || stall_o) begin
      AluOp_o    <= '0;
      AluSrc_o   <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      Branch_o   <= 1'b0;
      RegWrite_o <= 1'b0;
      MemToReg_o <= 1'b0;
      pc_plus4_o <= '0;
      rs_data_o  <= '0;
      rt_data_o  <= '0;
      imm_sext_o <= '0;
      rs_addr_o  <= '0;
      rt_addr_o  <= '0;
      wr_addr_o  <= '0;
      funct_o    <= '0;
      valid_o    <= 1'b0;
    end else begin
      // An empty ID slot must not carry side-effecting control into EX.
      AluOp_o    <= id_valid_i ? AluOp_i : 6'd0;
      AluSrc_o   <= id_valid_i & AluSrc_i;
      MemRead_o  <= id_valid_i & MemRead_i;
      MemWrite_o <= id_valid_i & MemWrite_i;
      Branch_o   <= id_valid_i & Branch_i;
      RegWrite_o <= id_valid_i & RegWrite_i;
      MemToReg_o <= id_valid_i & MemToReg_i;
      pc_plus4_o <= pc_plus4_i;
      rs_data_o  <= rs_data_i;
      rt_data_o  <= rt_data_i;
      imm_sext_o <= imm_sext_i;
      rs_addr_o  <= rs_addr_i;
      rt_addr_o  <= rt_addr_i;
      wr_addr_o  <= RegDst_i ? rd_addr_i : rt_addr_i;
      funct_o    <= funct_i;
      valid_o    <= id_valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (stall_o && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

endmodule
